// File: rtl/rx_frame_parser.sv
// Frame parser: qualifies the RX word stream, locks onto START/END framing, extracts the
// time stamp and forwards payload samples. Optional time-stamp continuity check: RX_FRAME_TS_CHECK_EN.
module rx_frame_parser #(
    parameter logic [15:0] START_WORD  = 16'hDEAD,
    parameter logic [15:0] END_WORD    = 16'hBEEF,
    parameter int unsigned PAYLOAD_LEN = 125,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             rx_std_clkout,
    input  logic             rst,
    input  logic [1:0]       rx_syncstatus,
    input  logic [1:0]       rx_datak,
    input  logic [15:0]      RX_data,
    output logic [15:0]      sample_data,
    output logic             sample_valid,
    output logic             sample_sof,
    output logic             sample_eof,
    output logic [15:0]      frame_ts,
    output logic             frame_ts_valid,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {StHunt, StTs, StPayload, StEndChk} state_e;

    localparam logic [15:0] LastIdx = 16'(PAYLOAD_LEN - 1);

    state_e      state;
    logic [15:0] pay_cnt;
    logic        link_ok;

    assign link_ok = (rx_syncstatus == 2'b11) && (rx_datak == 2'b00);

`ifdef RX_FRAME_TS_CHECK_EN
    logic [15:0] last_ts;
    logic        last_ts_valid;
    logic        ts_bad;

    // Modulo-2^16 wrap: 16'hFFFF followed by 16'h0000 is continuous.
    assign ts_bad = last_ts_valid && (RX_data != last_ts + 16'd1);
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge rx_std_clkout) begin
        if (rst) begin
            state          <= StHunt;
            pay_cnt        <= '0;
            sample_data    <= '0;
            sample_valid   <= 1'b0;
            sample_sof     <= 1'b0;
            sample_eof     <= 1'b0;
            frame_ts       <= '0;
            frame_ts_valid <= 1'b0;
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            err_code       <= 2'b00;
            frame_cnt      <= '0;
            err_cnt        <= '0;
`ifdef RX_FRAME_TS_CHECK_EN
            last_ts        <= '0;
            last_ts_valid  <= 1'b0;
`endif
        end else begin
            sample_valid   <= 1'b0;
            sample_sof     <= 1'b0;
            sample_eof     <= 1'b0;
            frame_ts_valid <= 1'b0;
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;

            if (!link_ok) begin
                // Losing the link inside a frame truncates it; idle loss in HUNT is harmless.
                if (state != StHunt) begin
                    state     <= StHunt;
                    frame_err <= 1'b1;
                    err_code  <= 2'b01;
                    err_cnt   <= sat_inc(err_cnt);
`ifdef RX_FRAME_TS_CHECK_EN
                    last_ts_valid <= 1'b0;
`endif
                end
            end else begin
                case (state)
                    StHunt: begin
                        if (RX_data == START_WORD) begin
                            state <= StTs;
                        end
                    end
                    StTs: begin
                        frame_ts       <= RX_data;
                        frame_ts_valid <= 1'b1;
                        pay_cnt        <= '0;
                        state          <= StPayload;
`ifdef RX_FRAME_TS_CHECK_EN
                        if (ts_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b11;
                            err_cnt   <= sat_inc(err_cnt);
                        end
                        last_ts       <= RX_data;
                        last_ts_valid <= 1'b1;
`endif
                    end
                    StPayload: begin
                        sample_data  <= RX_data;
                        sample_valid <= 1'b1;
                        sample_sof   <= (pay_cnt == 16'd0);
                        sample_eof   <= (pay_cnt == LastIdx);
                        if (pay_cnt == LastIdx) begin
                            state <= StEndChk;
                        end else begin
                            pay_cnt <= pay_cnt + 16'd1;
                        end
                    end
                    StEndChk: begin
                        if (RX_data == END_WORD) begin
                            frame_ok  <= 1'b1;
                            frame_cnt <= sat_inc(frame_cnt);
                            state     <= StHunt;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b10;
                            err_cnt   <= sat_inc(err_cnt);
                            // A START_WORD in the end slot is taken as the next frame's start.
                            state     <= (RX_data == START_WORD) ? StTs : StHunt;
                        end
                    end
                    default: state <= StHunt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: frames are built from a frame-level description and
// the expected output events (with their cycle stamps) are derived from that description.
module tb_rx_frame_parser;

    localparam logic [15:0] START = 16'hDEAD;
    localparam logic [15:0] ENDW  = 16'hBEEF;
    localparam int          L     = 125;

    typedef struct packed {logic [15:0] d; logic sof; logic eof; logic [31:0] cyc;} samp_t;
    typedef struct packed {logic [15:0] ts; logic [31:0] cyc;} ts_t;
    typedef struct packed {logic [1:0] code; logic [31:0] cyc;} err_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rx_syncstatus = 2'b11;
    logic [1:0]  rx_datak = 2'b00;
    logic [15:0] RX_data = '0;

    logic [15:0] sample_data, frame_ts;
    logic        sample_valid, sample_sof, sample_eof, frame_ts_valid, frame_ok, frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt, err_cnt;

    logic [15:0] s_sample_data, s_frame_ts;
    logic        s_sample_valid, s_sample_sof, s_sample_eof, s_frame_ts_valid, s_frame_ok;
    logic        s_frame_err;
    logic [1:0]  s_err_code;
    logic [1:0]  s_frame_cnt, s_err_cnt;

    rx_frame_parser u_dut (
        .rx_std_clkout(clk), .rst(rst), .rx_syncstatus(rx_syncstatus), .rx_datak(rx_datak),
        .RX_data(RX_data), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_sof(sample_sof), .sample_eof(sample_eof), .frame_ts(frame_ts),
        .frame_ts_valid(frame_ts_valid), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    // Narrow-counter instance, driven identically, exposes saturation.
    rx_frame_parser #(.CNT_W(2)) u_sat (
        .rx_std_clkout(clk), .rst(rst), .rx_syncstatus(rx_syncstatus), .rx_datak(rx_datak),
        .RX_data(RX_data), .sample_data(s_sample_data), .sample_valid(s_sample_valid),
        .sample_sof(s_sample_sof), .sample_eof(s_sample_eof), .frame_ts(s_frame_ts),
        .frame_ts_valid(s_frame_ts_valid), .frame_ok(s_frame_ok), .frame_err(s_frame_err),
        .err_code(s_err_code), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cyc = '0;
    logic [31:0] drv_n = '0;

    samp_t       obs_s[$], exp_s[$];
    ts_t         obs_t[$], exp_t[$];
    err_t        obs_e[$], exp_e[$];
    logic [31:0] obs_o[$], exp_o[$];

    // Reference state at frame level.
    int          m_frame_cnt = 0;
    int          m_err_cnt = 0;
    logic [1:0]  m_err_code = 2'b00;
    logic [15:0] m_ts = '0;
    logic [15:0] m_last_ts = '0;
    bit          m_last_ts_valid = 0;
    bit          pending_ts = 0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk) begin
        if (sample_valid === 1'b1) obs_s.push_back({sample_data, sample_sof, sample_eof, cyc});
        if (frame_ts_valid === 1'b1) obs_t.push_back({frame_ts, cyc});
        if (frame_err === 1'b1) obs_e.push_back({err_code, cyc});
        if (frame_ok === 1'b1) obs_o.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] w, input logic [1:0] s, input logic [1:0] k);
        RX_data = w;
        rx_syncstatus = s;
        rx_datak = k;
        @(posedge clk);
        drv_n++;
        #1;
    endtask

    task automatic raise_err(input logic [1:0] code);
        exp_e.push_back({code, drv_n});
        m_err_cnt++;
        m_err_code = code;
    endtask

    task automatic model_reset();
        m_frame_cnt = 0;
        m_err_cnt = 0;
        m_err_code = 2'b00;
        m_ts = '0;
        m_last_ts_valid = 0;
        pending_ts = 0;
    endtask

    // cut_kind: 0 none, 1 link drop at word cut_at (L = end slot), 2 two-cycle reset at cut_at.
    task automatic send_frame(input logic [15:0] ts, input int cut_at, input int cut_kind,
                              input logic [15:0] endw, input bit incr);
        logic [15:0] d;
        if (!pending_ts) drive(START, 2'b11, 2'b00);
        pending_ts = 0;
        drive(ts, 2'b11, 2'b00);
        exp_t.push_back({ts, drv_n});
        m_ts = ts;
`ifdef RX_FRAME_TS_CHECK_EN
        if (m_last_ts_valid && ts != m_last_ts + 16'd1) raise_err(2'b11);
        m_last_ts = ts;
        m_last_ts_valid = 1;
`endif
        for (int i = 0; i <= L; i++) begin
            if (cut_kind != 0 && i == cut_at) begin
                if (cut_kind == 1) begin
                    drive(16'($urandom), 2'b01, 2'b00);
                    raise_err(2'b01);
                    m_last_ts_valid = 0;
                end else begin
                    rst = 1'b1;
                    drive(16'($urandom), 2'b11, 2'b00);
                    drive(16'($urandom), 2'b11, 2'b00);
                    model_reset();
                end
                return;
            end
            if (i < L) begin
                d = incr ? 16'(i) : 16'($urandom);
                drive(d, 2'b11, 2'b00);
                exp_s.push_back({d, (i == 0), (i == L - 1), drv_n});
            end else begin
                drive(endw, 2'b11, 2'b00);
                if (endw == ENDW) begin
                    exp_o.push_back(drv_n);
                    m_frame_cnt++;
                end else begin
                    raise_err(2'b10);
                    pending_ts = (endw == START);
                end
            end
        end
    endtask

    task automatic send_unqualified(input logic [15:0] ts);
        logic [1:0] s, k;
        for (int i = 0; i < L + 3; i++) begin
            s = 2'($urandom_range(0, 3));
            k = 2'($urandom_range(0, 3));
            if (s == 2'b11 && k == 2'b00) k = 2'b01;
            drive((i == 0) ? START : (i == 1) ? ts : (i == L + 2) ? ENDW : 16'($urandom), s, k);
        end
    endtask

    task automatic check_point(input string tag);
        drive(16'h0000, 2'b11, 2'b00);
        check({tag, "_n_samples"}, 64'(obs_s.size()), 64'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++)
            check({tag, "_sample"}, 64'(obs_s[i]), 64'(exp_s[i]));
        check({tag, "_n_ts"}, 64'(obs_t.size()), 64'(exp_t.size()));
        for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++)
            check({tag, "_ts_pulse"}, 64'(obs_t[i]), 64'(exp_t[i]));
        check({tag, "_n_err"}, 64'(obs_e.size()), 64'(exp_e.size()));
        for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++)
            check({tag, "_err_pulse"}, 64'(obs_e[i]), 64'(exp_e[i]));
        check({tag, "_n_ok"}, 64'(obs_o.size()), 64'(exp_o.size()));
        for (int i = 0; i < exp_o.size() && i < obs_o.size(); i++)
            check({tag, "_ok_pulse"}, 64'(obs_o[i]), 64'(exp_o[i]));
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frame_cnt));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(m_err_cnt));
        check({tag, "_err_code"}, 64'(err_code), 64'(m_err_code));
        check({tag, "_frame_ts"}, 64'(frame_ts), 64'(m_ts));
        check({tag, "_sat_frame_cnt"}, 64'(s_frame_cnt), 64'((m_frame_cnt > 3) ? 3 : m_frame_cnt));
        check({tag, "_sat_err_cnt"}, 64'(s_err_cnt), 64'((m_err_cnt > 3) ? 3 : m_err_cnt));
        obs_s.delete(); exp_s.delete(); obs_t.delete(); exp_t.delete();
        obs_e.delete(); exp_e.delete(); obs_o.delete(); exp_o.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_outs"}, 64'({sample_data, sample_valid, sample_sof, sample_eof,
                                        frame_ts, frame_ts_valid, frame_ok, frame_err, err_code}),
              64'(0));
        check({tag, "_counters"}, 64'({frame_cnt, err_cnt}), 64'(0));
    endtask

    initial begin
        int nsof, neof, kind, cut;
        logic [15:0] ts, bad;

        drive(16'h0000, 2'b11, 2'b00);
        drive(16'h0000, 2'b11, 2'b00);
        check_all_zero("reset");
        rst = 1'b0;

        // Four back-to-back frames with incrementing payload.
        for (int f = 0; f < 4; f++) send_frame(16'h0045 + 16'(f), -1, 0, ENDW, 1);
        drive(16'h0000, 2'b11, 2'b00);
        nsof = 0;
        neof = 0;
        foreach (obs_s[i]) begin
            nsof += int'(obs_s[i].sof);
            neof += int'(obs_s[i].eof);
        end
        check("b2b_sof_count", 64'(nsof), 64'(4));
        check("b2b_eof_count", 64'(neof), 64'(4));
        check_point("b2b");

        // Frames presented while the link is not qualified, then a clean frame.
        send_unqualified(16'h0049);
        send_unqualified(16'h004A);
        check_point("unqual");
        send_frame(16'h0049, -1, 0, ENDW, 0);
        check_point("after_unqual");

        // Link drop inside the payload and in the end-word slot.
        send_frame(16'h004A, 60, 1, ENDW, 0);
        send_frame(16'h0060, -1, 0, ENDW, 0);
        check_point("drop_payload");
        send_frame(16'h0061, L, 1, ENDW, 0);
        send_frame(16'h0062, -1, 0, ENDW, 0);
        check_point("drop_endchk");

        // Bad end words: START_WORD resyncs straight into the time stamp, others go to hunt.
        send_frame(16'h0063, -1, 0, START, 0);
        send_frame(16'h0064, -1, 0, ENDW, 0);
        check_point("bad_end_resync");
        send_frame(16'h0065, -1, 0, 16'h1234, 0);
        send_frame(16'h0066, -1, 0, ENDW, 0);
        check_point("bad_end_hunt");

        // Time-stamp sequences including a jump and a wrap.
        send_frame(16'h0045, -1, 0, ENDW, 0);
        send_frame(16'h0046, -1, 0, ENDW, 0);
        send_frame(16'h0050, -1, 0, ENDW, 0);
        check_point("ts_jump");
        send_frame(16'hFFFF, -1, 0, ENDW, 0);
        send_frame(16'h0000, -1, 0, ENDW, 0);
        check_point("ts_wrap");

        // Randomized mix of frame outcomes.
        ts = 16'h1000;
        for (int f = 0; f < 8; f++) begin
            kind = int'($urandom_range(0, 3));
            ts = (kind == 3) ? 16'($urandom) : ts + 16'd1;
            if (!pending_ts) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--)
                    drive(16'h0001 + 16'($urandom_range(0, 16'h7FFF)), 2'b11, 2'b00);
            end
            if (kind == 1) begin
                bad = ($urandom_range(0, 1) == 1) ? START : 16'($urandom);
                if (bad == ENDW) bad = 16'h0BAD;
                send_frame(ts, -1, 0, bad, 0);
            end else if (kind == 2) begin
                cut = int'($urandom_range(0, L));
                send_frame(ts, cut, 1, ENDW, 0);
            end else begin
                send_frame(ts, -1, 0, ENDW, 0);
            end
        end
        send_frame(ts + 16'd1, -1, 0, ENDW, 0);
        check_point("random");

        // Reset in the middle of a frame discards it silently.
        send_frame(16'h0070, 30, 2, ENDW, 0);
        check_all_zero("mid_reset");
        rst = 1'b0;
        send_frame(16'h0071, -1, 0, ENDW, 0);
        check_point("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
